// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, datapath
// mux selects, ALU operation classes and controller state.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] NO_ALU         = 2'b00;
    localparam logic [1:0] BRANCH_COMPARE = 2'b01;
    localparam logic [1:0] ADD_OFFSET     = 2'b10;
    localparam logic [1:0] ARITHMETIC     = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] A_RS1    = 2'd0;
    localparam logic [1:0] A_OLD_PC = 2'd1;
    localparam logic [1:0] A_ZERO   = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    typedef enum logic [2:0] {
        S_WAIT, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_LUI, CLS_AUIPC,
        CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode classifier; anything the core cannot execute
// (including SYSTEM and reserved branch funct3) collapses to CLS_ILLEGAL.
module main_decoder
    import riscv_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t instr_class,
    output logic         illegal
);

    logic [2:0] funct3;
    assign funct3 = instr[14:12];

    always_comb begin
        instr_class = CLS_ILLEGAL;
        case (instr[6:0])
            OP_R:      instr_class = CLS_R;
            OP_I:      instr_class = CLS_I;
            OP_LOAD:   instr_class = CLS_LOAD;
            OP_STORE:  instr_class = CLS_STORE;
            OP_LUI:    instr_class = CLS_LUI;
            OP_AUIPC:  instr_class = CLS_AUIPC;
            OP_BRANCH: instr_class = (funct3 == 3'b010 || funct3 == 3'b011) ? CLS_ILLEGAL
                                                                            : CLS_BRANCH;
            OP_JAL:    instr_class = CLS_JAL;
            OP_JALR:   instr_class = CLS_JALR;
            default:   instr_class = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: one instruction at a time
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, halting in TRAP on illegal code.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int RESET_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        branch_condition_match,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_operation,
    output logic [1:0]  alu_a_sel,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        is_rtype,
    output logic        retire,
    output logic        halted
);

    localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT - 1);
    localparam state_t     RST_STATE = (RESET_WAIT == 0) ? S_FETCH : S_WAIT;

    state_t       state, next_state;
    logic [3:0]   wait_cnt;
    instr_class_t cls;
    logic         illegal;

    main_decoder u_dec (
        .instr       (instr),
        .instr_class (cls),
        .illegal     (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RST_STATE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    // Outputs are gated by rst so an in-flight memory request drops immediately.
    always_comb begin
        next_state    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        alu_operation = NO_ALU;
        alu_a_sel     = A_RS1;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        is_rtype      = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        if (!rst) begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) next_state = S_FETCH;
                end
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    next_state = illegal ? S_TRAP : S_EXECUTE;
                end
                S_EXECUTE: begin
                    next_state = S_WRITEBACK;
                    case (cls)
                        CLS_R: begin
                            alu_operation = ARITHMETIC;
                            is_rtype      = 1'b1;
                        end
                        CLS_I: begin
                            alu_operation = ARITHMETIC;
                            alu_src       = 1'b1;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_operation = ADD_OFFSET;
                            alu_src       = 1'b1;
                            next_state    = S_MEM;
                        end
                        CLS_LUI: begin
                            alu_operation = ADD_OFFSET;
                            alu_a_sel     = A_ZERO;
                            alu_src       = 1'b1;
                        end
                        CLS_AUIPC: begin
                            alu_operation = ADD_OFFSET;
                            alu_a_sel     = A_OLD_PC;
                            alu_src       = 1'b1;
                        end
                        CLS_BRANCH: begin
                            alu_operation = BRANCH_COMPARE;
                            pc_write      = branch_condition_match;
                            pc_src        = PC_BRANCH;
                            retire        = 1'b1;
                            next_state    = S_FETCH;
                        end
                        CLS_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = PC_BRANCH;
                        end
                        CLS_JALR: begin
                            alu_operation = ADD_OFFSET;
                            alu_src       = 1'b1;
                            pc_write      = 1'b1;
                            pc_src        = PC_ALU;
                        end
                        default: next_state = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req       = 1'b1;
                    mem_addr_sel  = 1'b1;
                    mem_we        = (cls == CLS_STORE);
                    alu_operation = ADD_OFFSET;
                    alu_src       = 1'b1;
                    if (mem_ready) begin
                        if (cls == CLS_STORE) begin
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end else begin
                            next_state = S_WRITEBACK;
                        end
                    end
                end
                S_WRITEBACK: begin
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                    if (cls == CLS_LOAD)                          wb_sel = WB_LOAD;
                    else if (cls == CLS_JAL || cls == CLS_JALR)   wb_sel = WB_PC4;
                end
                S_TRAP: halted = 1'b1;
                default: next_state = S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: table of single instructions with
// zero-wait memory, then hand-written stall, trap and reset-abort sequences.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        branch_condition_match = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src, alu_operation, alu_a_sel, wb_sel;
    logic        alu_src, reg_write, is_rtype, retire, halted;

    int total = 0;
    int bad   = 0;

    multicycle_controller #(.RESET_WAIT(0)) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .branch_condition_match(branch_condition_match), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_operation(alu_operation), .alu_a_sel(alu_a_sel), .alu_src(alu_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .is_rtype(is_rtype),
        .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_src, alu_operation, alu_a_sel, alu_src, is_rtype}
    logic [8:0]  exec_now;
    // {reg_write, wb_sel, mem_req, mem_we, mem_addr_sel, retire}
    logic [6:0]  last_now;
    logic [16:0] strobes;
    assign exec_now = {pc_write, pc_src, alu_operation, alu_a_sel, alu_src, is_rtype};
    assign last_now = {reg_write, wb_sel, mem_req, mem_we, mem_addr_sel, retire};
    assign strobes  = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                       alu_operation, alu_a_sel, alu_src, reg_write, wb_sel,
                       is_rtype, retire};

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        match;
        int          ncyc;
        logic [8:0]  exec_w;
        logic [6:0]  last_w;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT at the start of a FETCH cycle with rst low.
    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("reset_outputs", {15'd0, strobes}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit done  = 0;
        bit early = 0;
        instr = v.ins;
        branch_condition_match = v.match;
        mem_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) check({v.name, "_ir_write"}, {31'd0, ir_write}, 32'd1);
            if (c == 2) check({v.name, "_exec"}, {23'd0, exec_now}, {23'd0, v.exec_w});
            if (retire) begin
                check({v.name, "_cycles"}, c + 1, v.ncyc);
                check({v.name, "_last"}, {25'd0, last_now}, {25'd0, v.last_w});
                done = 1;
            end else if (reg_write) begin
                early = 1;
            end
            next_cycle();
            if (done) break;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s_timeout: no retire within 30 cycles", v.name);
        end
        check({v.name, "_early_wr"}, {31'd0, early}, 32'd0);
        // Stall the following FETCH one cycle to observe the 1-cycle re-request.
        mem_ready = 1'b0;
        @(negedge clk);
        check({v.name, "_next_req"}, {30'd0, mem_req, ir_write}, 32'd2);
        next_cycle();
    endtask

    initial begin
        vecs[0] = '{"add",    32'h002081B3, 1'b0, 4, 9'b0_00_11_00_0_1, 7'b1_00_000_1};
        vecs[1] = '{"addi",   32'h00500093, 1'b0, 4, 9'b0_00_11_00_1_0, 7'b1_00_000_1};
        vecs[2] = '{"lw",     32'h0080A283, 1'b0, 5, 9'b0_00_10_00_1_0, 7'b1_01_000_1};
        vecs[3] = '{"sw",     32'h0020A223, 1'b0, 4, 9'b0_00_10_00_1_0, 7'b0_00_111_1};
        vecs[4] = '{"lui",    32'h123450B7, 1'b0, 4, 9'b0_00_10_10_1_0, 7'b1_00_000_1};
        vecs[5] = '{"auipc",  32'h00001117, 1'b0, 4, 9'b0_00_10_01_1_0, 7'b1_00_000_1};
        vecs[6] = '{"beq_t",  32'h00208463, 1'b1, 3, 9'b1_01_01_00_0_0, 7'b0_00_000_1};
        vecs[7] = '{"beq_nt", 32'h00208463, 1'b0, 3, 9'b0_01_01_00_0_0, 7'b0_00_000_1};
        vecs[8] = '{"jal",    32'h010000EF, 1'b0, 4, 9'b1_01_00_00_0_0, 7'b1_10_000_1};
        vecs[9] = '{"jalr",   32'h000080E7, 1'b0, 4, 9'b1_10_10_00_1_0, 7'b1_10_000_1};

        do_reset();
        foreach (vecs[i]) run_vec(vecs[i]);

        // Load with two wait cycles in both FETCH and MEM.
        begin
            bit done = 0;
            do_reset();
            instr = 32'h0080A283;
            for (int c = 0; c < 30; c++) begin
                mem_ready = (c == 2 || c == 7);
                @(negedge clk);
                if (c <= 2) check($sformatf("lw_wait_fetch%0d", c),
                                  {30'd0, mem_req, mem_addr_sel}, 32'd2);
                if (c >= 5 && c <= 7) check($sformatf("lw_wait_mem%0d", c),
                                            {29'd0, mem_req, mem_addr_sel, mem_we}, 32'd6);
                if (retire) begin
                    check("lw_wait_cycles", c + 1, 9);
                    check("lw_wait_wb", {29'd0, reg_write, wb_sel}, 32'd5);
                    done = 1;
                end
                next_cycle();
                if (done) break;
            end
            if (!done) begin
                total++; bad++;
                $display("FAIL lw_wait_timeout: no retire within 30 cycles");
            end
        end

        // Illegal encodings: unknown opcode, SYSTEM, branch funct3 010.
        begin
            logic [31:0] ill[3];
            ill[0] = 32'h0000007F;
            ill[1] = 32'h00000073;
            ill[2] = 32'h00002063;
            for (int k = 0; k < 3; k++) begin
                int wrong = 0;
                do_reset();
                instr = ill[k];
                mem_ready = 1'b1;
                for (int c = 0; c < 22; c++) begin
                    @(negedge clk);
                    if (c < 2 && halted) wrong++;
                    if (c >= 2 && (!halted || strobes != 17'd0)) wrong++;
                    next_cycle();
                end
                check($sformatf("trap%0d_cycles_wrong", k), wrong, 0);
                rst = 1'b1;
                @(negedge clk);
                check($sformatf("trap%0d_rst_halted", k), {31'd0, halted}, 32'd0);
                next_cycle();
                rst = 1'b0;
                @(negedge clk);
                check($sformatf("trap%0d_refetch", k), {30'd0, mem_req, halted}, 32'd2);
                next_cycle();
            end
        end

        // Reset while a store is stalled in MEM.
        begin
            bit ret_seen = 0;
            do_reset();
            instr = 32'h0020A223;
            for (int c = 0; c < 6; c++) begin
                mem_ready = (c == 0);
                rst = (c == 4);
                @(negedge clk);
                if (retire) ret_seen = 1;
                if (c == 3) check("sw_rst_mem", {29'd0, mem_req, mem_we, mem_addr_sel}, 32'd7);
                if (c == 4) check("sw_rst_drop", {30'd0, mem_req, mem_we}, 32'd0);
                if (c == 5) check("sw_rst_fetch", {30'd0, mem_req, mem_we}, 32'd2);
                next_cycle();
            end
            check("sw_rst_no_retire", {31'd0, ret_seen}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
